render_compositor: RTL and testbench

Parametrised pixel-domain compositor, the next generation of the scene-select/mouse-overlay output stage. It selects one of NUM_SCENES scene pixel streams and layers NUM_OVERLAYS colour-keyed overlays on top by fixed priority. A frame-synchronous fade state machine performs fade-out/fade-in transitions on scene change. It drives the VGA DAC pins directly through a 2-stage registered pipeline.

---
 rtl/render_compositor_if.sv | 38 +++
 rtl/render_compositor.sv | 178 +++++++++++++++++
 tb/tb_render_compositor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/render_compositor_if.sv
// Pixel-side bundle of the render compositor: scene/overlay pixel inputs,
// frame timing and fade control from the video source, plus the VGA DAC pins
// and transition status going back out.
interface render_compositor_if #(
    parameter int NUM_SCENES   = 8,
    parameter int NUM_OVERLAYS = 2,
    parameter int FADE_FRAMES  = 16
);
    localparam int SW = $clog2(NUM_SCENES);
    localparam int LW = $clog2(FADE_FRAMES) + 1;

    logic                      valid;
    logic                      frame_start;
    logic [SW-1:0]             scene;
    logic [12*NUM_SCENES-1:0]  scene_pixels;
    logic [NUM_OVERLAYS-1:0]   overlay_en;
    logic [12*NUM_OVERLAYS-1:0] overlay_pixels;
    logic                      fade_enable;
    logic [3:0]                vgaRed;
    logic [3:0]                vgaGreen;
    logic [3:0]                vgaBlue;
    logic                      busy;
    logic [LW-1:0]             fade_level;

    // Video source side: drives pixels and control, watches the pins.
    modport master (
        output valid, frame_start, scene, scene_pixels,
               overlay_en, overlay_pixels, fade_enable,
        input  vgaRed, vgaGreen, vgaBlue, busy, fade_level
    );

    // Compositor side.
    modport slave (
        input  valid, frame_start, scene, scene_pixels,
               overlay_en, overlay_pixels, fade_enable,
        output vgaRed, vgaGreen, vgaBlue, busy, fade_level
    );
endinterface

// File: rtl/render_compositor.sv
// Scene-select / overlay compositor with frame-synchronous fade transitions.
// Stage 1 picks the shown scene pixel and resolves overlays by priority;
// stage 2 applies the brightness scale (overlays stay unfaded) and drives
// the VGA DAC pins. A small FSM steps the fade level on frame_start.
module render_compositor #(
    parameter int          NUM_SCENES   = 8,
    parameter int          NUM_OVERLAYS = 2,
    parameter int          FADE_FRAMES  = 16,
    parameter logic [11:0] TRANSPARENT  = 12'hF0F
) (
    input logic          clk_25MHz,
    input logic          rst,
    render_compositor_if.slave bus
);
    localparam int SW = $clog2(NUM_SCENES);
    localparam int FS = $clog2(FADE_FRAMES);
    localparam int LW = FS + 1;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(FADE_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] level, level_nxt;
    logic [SW-1:0] shown_scene, shown_nxt;
    logic          busy_q;

    // Stage 1 pipeline registers.
    logic          s1_valid;
    logic          s1_hit;
    logic [11:0]   s1_pixel;
    logic [LW-1:0] s1_level;

    // Stage 1 combinational selections.
    logic [11:0]   base_pixel;
    logic [11:0]   ov_pixel;
    logic          ov_hit;

    // Stage 2 output register and its combinational input.
    logic [11:0]   out_pixel;
    logic [11:0]   out_nxt;

    // Scale one 4-bit channel by level/FADE_FRAMES; exact at both ends.
    function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [LW-1:0] lvl);
        logic [4+LW-1:0] prod;
        prod = (4+LW)'(c) * (4+LW)'(lvl);
        return 4'(prod >> FS);
    endfunction

    // Fade FSM: next state, next level and scene swap.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_nxt = state;
        level_nxt = level;
        shown_nxt = shown_scene;
        unique case (state)
            IDLE: begin
                level_nxt = LEVEL_MAX;
                if (bus.scene != shown_scene) begin
                    if (bus.fade_enable) state_nxt = FADE_OUT;
                    else                 shown_nxt = bus.scene;
                end
            end
            FADE_OUT: begin
                if (bus.scene == shown_scene) begin
                    // Request withdrawn: brighten back from where we are.
                    state_nxt = FADE_IN;
                end else if (bus.frame_start) begin
                    if (level <= LW'(1)) begin
                        // Fully dark: take whatever scene is requested now.
                        level_nxt = '0;
                        shown_nxt = bus.scene;
                        state_nxt = FADE_IN;
                    end else begin
                        level_nxt = level - LW'(1);
                    end
                end
            end
            FADE_IN: begin
                if (bus.scene != shown_scene) begin
                    // New request while brightening: darken from here.
                    state_nxt = FADE_OUT;
                end else if (bus.frame_start) begin
                    if (level >= LEVEL_MAX - LW'(1)) begin
                        level_nxt = LEVEL_MAX;
                        state_nxt = IDLE;
                    end else begin
                        level_nxt = level + LW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = LEVEL_MAX;
            end
        endcase
    end

    // Fade FSM registers; busy is registered alongside the state.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state       <= IDLE;
            level       <= LEVEL_MAX;
            shown_scene <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            level       <= level_nxt;
            shown_scene <= shown_nxt;
            busy_q      <= (state_nxt != IDLE);
        end
    end

    // Base scene mux; an index beyond the populated scenes yields black.
    always_comb begin
        base_pixel = 12'h000;
        for (int k = 0; k < NUM_SCENES; k++) begin
            if (shown_scene == SW'(k)) base_pixel = bus.scene_pixels[12*k +: 12];
        end
    end

    // Overlay priority search; scanning downward lets the lowest index win.
    always_comb begin
        ov_hit   = 1'b0;
        ov_pixel = 12'h000;
        for (int i = NUM_OVERLAYS - 1; i >= 0; i--) begin
            if (bus.overlay_en[i] && (bus.overlay_pixels[12*i +: 12] != TRANSPARENT)) begin
                ov_hit   = 1'b1;
                ov_pixel = bus.overlay_pixels[12*i +: 12];
            end
        end
    end

    // Stage 1 register: winning pixel, hit flag, valid and the current level.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_pixel <= 12'h000;
            s1_level <= '0;
        end else begin
            s1_valid <= bus.valid;
            s1_hit   <= ov_hit;
            s1_pixel <= ov_hit ? ov_pixel : base_pixel;
            s1_level <= level;
        end
    end

    // Stage 2 pixel: blank outside active video, overlays bypass the fade.
    always_comb begin
        out_nxt = 12'h000;
        if (s1_valid) begin
            if (s1_hit) out_nxt = s1_pixel;
            else        out_nxt = {fade_ch(s1_pixel[11:8], s1_level),
                                   fade_ch(s1_pixel[7:4],  s1_level),
                                   fade_ch(s1_pixel[3:0],  s1_level)};
        end
    end

    // Stage 2 register feeding the DAC pins.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) out_pixel <= 12'h000;
        else      out_pixel <= out_nxt;
    end

    assign bus.vgaRed     = out_pixel[11:8];
    assign bus.vgaGreen   = out_pixel[7:4];
    assign bus.vgaBlue    = out_pixel[3:0];
    assign bus.busy       = busy_q;
    assign bus.fade_level = level;

endmodule

// File: tb/tb_render_compositor.sv
// Directed bench for render_compositor with FADE_FRAMES=4: pass-through,
// overlay priority, full fade, immediate switch, retarget/reverse and
// asynchronous reset mid-fade.
module tb_render_compositor;
    localparam int NS = 8;
    localparam int NO = 2;
    localparam int FF = 4;

    logic clk_25MHz;
    logic rst;
    int   n_tests;
    int   n_fail;

    render_compositor_if #(.NUM_SCENES(NS), .NUM_OVERLAYS(NO), .FADE_FRAMES(FF)) bus ();

    render_compositor #(
        .NUM_SCENES(NS), .NUM_OVERLAYS(NO), .FADE_FRAMES(FF), .TRANSPARENT(12'hF0F)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_25MHz);
        #1;
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        cyc(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic set_scene_pix(input int k, input logic [11:0] p);
        bus.scene_pixels[12*k +: 12] = p;
    endtask

    function automatic logic [11:0] pins();
        return {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
    endfunction

    task automatic do_reset();
        rst                = 1'b0;
        bus.valid          = 1'b1;
        bus.frame_start    = 1'b0;
        bus.scene          = '0;
        bus.scene_pixels   = '0;
        bus.overlay_en     = '0;
        bus.overlay_pixels = '0;
        bus.fade_enable    = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    logic [2:0]  exp_lvl  [8] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [11:0] exp_pix  [8] = '{12'hBBB, 12'h777, 12'h333, 12'h000,
                                  12'h222, 12'h444, 12'h666, 12'h888};
    logic        exp_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // 1: reset state, pass-through latency, blanking.
        do_reset();
        check("rst_pins", 32'(pins()), 32'h000);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_level", 32'(bus.fade_level), 32'd4);
        set_scene_pix(0, 12'h48C);
        cyc(1);
        check("lat_1cyc", 32'(pins()), 32'h000);
        cyc(1);
        check("pass_48C", 32'(pins()), 32'h48C);
        bus.valid = 1'b0;
        cyc(1);
        check("blank_lat1", 32'(pins()), 32'h48C);
        cyc(1);
        check("blank", 32'(pins()), 32'h000);

        // 2: overlay priority and colour key.
        bus.valid = 1'b1;
        set_scene_pix(0, 12'h123);
        bus.overlay_en     = 2'b11;
        bus.overlay_pixels = {12'h0F0, 12'hF0F};
        cyc(2);
        check("ov_key_skip", 32'(pins()), 32'h0F0);
        bus.overlay_pixels = {12'h0F0, 12'hFFF};
        cyc(2);
        check("ov0_wins", 32'(pins()), 32'hFFF);
        bus.overlay_en = 2'b10;
        cyc(2);
        check("ov0_disabled", 32'(pins()), 32'h0F0);
        bus.overlay_en = 2'b00;
        cyc(2);
        check("ov_none", 32'(pins()), 32'h123);

        // 3: full fade 0 -> 2 with a coincident frame_start on the request.
        do_reset();
        bus.fade_enable = 1'b1;
        set_scene_pix(0, 12'hFFF);
        set_scene_pix(2, 12'h888);
        cyc(2);
        check("f_start_pix", 32'(pins()), 32'hFFF);
        bus.scene       = 3'd2;
        bus.frame_start = 1'b1;
        cyc(1);
        bus.frame_start = 1'b0;
        check("f_enter_busy", 32'(bus.busy), 32'h1);
        check("f_enter_lvl", 32'(bus.fade_level), 32'd4);
        for (int i = 0; i < 8; i++) begin
            frame_pulse();
            check($sformatf("f_lvl%0d", i), 32'(bus.fade_level), 32'(exp_lvl[i]));
            check($sformatf("f_busy%0d", i), 32'(bus.busy), 32'(exp_busy[i]));
            cyc(2);
            check($sformatf("f_pix%0d", i), 32'(pins()), 32'(exp_pix[i]));
        end

        // 4: immediate switch without fading.
        do_reset();
        for (int k = 0; k < NS; k++) set_scene_pix(k, 12'h0A5 + 12'(k << 8));
        bus.scene = 3'd1;
        cyc(3);
        check("sw_scene1", 32'(pins()), 32'h1A5);
        bus.scene = 3'd3;
        cyc(1);
        check("sw_shown", 32'(dut.shown_scene), 32'd3);
        check("sw_busy", 32'(bus.busy), 32'h0);
        check("sw_level", 32'(bus.fade_level), 32'd4);
        cyc(2);
        check("sw_pix", 32'(pins()), 32'h3A5);

        // 5a: retarget to scene 5 during FADE_IN at level 2.
        do_reset();
        bus.fade_enable = 1'b1;
        set_scene_pix(0, 12'hFFF);
        set_scene_pix(2, 12'h888);
        set_scene_pix(5, 12'h444);
        bus.scene = 3'd2;
        cyc(1);
        repeat (6) frame_pulse();
        check("rt_in_lvl2", 32'(bus.fade_level), 32'd2);
        bus.scene = 3'd5;
        cyc(1);
        check("rt_hold_lvl", 32'(bus.fade_level), 32'd2);
        check("rt_busy", 32'(bus.busy), 32'h1);
        frame_pulse();
        check("rt_lvl1", 32'(bus.fade_level), 32'd1);
        frame_pulse();
        check("rt_lvl0", 32'(bus.fade_level), 32'd0);
        check("rt_shown5", 32'(dut.shown_scene), 32'd5);
        frame_pulse();
        cyc(2);
        check("rt_pix_l1", 32'(pins()), 32'h111);
        repeat (3) frame_pulse();
        check("rt_done", 32'(bus.busy), 32'h0);
        cyc(2);
        check("rt_pix_full", 32'(pins()), 32'h444);

        // 5b: withdraw the request during FADE_OUT at level 3.
        do_reset();
        bus.fade_enable = 1'b1;
        set_scene_pix(0, 12'hFFF);
        set_scene_pix(2, 12'h888);
        bus.scene = 3'd2;
        cyc(1);
        frame_pulse();
        check("rv_lvl3", 32'(bus.fade_level), 32'd3);
        bus.scene = 3'd0;
        cyc(1);
        check("rv_hold", 32'(bus.fade_level), 32'd3);
        check("rv_shown0", 32'(dut.shown_scene), 32'd0);
        frame_pulse();
        check("rv_lvl4", 32'(bus.fade_level), 32'd4);
        check("rv_idle", 32'(bus.busy), 32'h0);
        cyc(2);
        check("rv_pix", 32'(pins()), 32'hFFF);

        // 6: asynchronous reset mid FADE_OUT at level 2.
        do_reset();
        bus.fade_enable = 1'b1;
        set_scene_pix(0, 12'hFFF);
        bus.scene = 3'd2;
        cyc(1);
        repeat (2) frame_pulse();
        cyc(2);
        check("ar_pre_pix", 32'(pins()), 32'h777);
        #5;
        rst = 1'b0;
        #1;
        check("ar_pix", 32'(pins()), 32'h000);
        check("ar_busy", 32'(bus.busy), 32'h0);
        check("ar_level", 32'(bus.fade_level), 32'd4);
        check("ar_shown", 32'(dut.shown_scene), 32'd0);
        cyc(1);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
